// File: rtl/spike_queue_pkg.sv
// Shared types and helpers for the multi-channel spike input queue.
package spike_queue_pkg;

   localparam int SPIKE_B = 8;
   localparam int Q_W     = 4;

   typedef logic [SPIKE_B-1:0] spike_idx_t;

   typedef struct packed {
      logic [2:0] src;
      spike_idx_t data;
   } q_entry_t;

   // Index width that stays at least one bit, even for a single channel.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spike_input_queue_mc_rr_arbiter.sv
// Round-robin grant for the queue write channels; the pointer moves past the
// last accepted channel so that every requester is eventually served.
module rr_arbiter
   import spike_queue_pkg::*;
#(
   parameter int CH = 2
) (
   input  logic          clk,
   input  logic          reset_input_queue,
   input  logic          clr,
   input  logic [CH-1:0] req,
   input  logic          en,
   input  logic          advance,
   output logic [CH-1:0] gnt
);

   localparam int PW = clog2_min1(CH);

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] gnt_idx;

   // Scan from the highest offset down so the nearest requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int k = CH - 1; k >= 0; k--) begin
         logic [PW-1:0] c;
         c = PW'((int'(rr_ptr) + k) % CH);
         if (en && req[c]) begin
            gnt     = '0;
            gnt[c]  = 1'b1;
            gnt_idx = c;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_input_queue) begin
      if (reset_input_queue) begin
         rr_ptr <= '0;
      end else if (clr) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (int'(gnt_idx) == CH - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/spike_input_queue_mc.sv
// Multi-channel FWFT spike queue: round-robin merge of CH writers into 2^W
// entries. Optional stats outputs enabled by SPIKE_QUEUE_STATS_EN.
module spike_input_queue_mc
   import spike_queue_pkg::*;
#(
   parameter  int B         = SPIKE_B,
   parameter  int W         = Q_W,
   parameter  int CH        = 2,
   parameter  int AF_MARGIN = 2,
   localparam int SW        = clog2_min1(CH)
) (
   input  logic            clk,
   input  logic            reset_input_queue,
   input  logic            clr_input_queue,
   input  logic [CH-1:0]   wr_input_queue,
   input  logic [CH*B-1:0] w_data_input_queue,
   output logic [CH-1:0]   wr_ready,
   input  logic            rd_input_queue,
   output logic [B-1:0]    r_data_input_queue,
   output logic [SW-1:0]   r_src,
   output logic [W:0]      count,
   output logic            empty_input_queue,
   output logic            full_input_queue,
   output logic            almost_full
`ifdef SPIKE_QUEUE_STATS_EN
   ,
   output logic [W:0]      high_water,
   output logic [15:0]     stall_cnt
`endif
);

   localparam int DEPTH = 1 << W;

   typedef struct packed {
      logic [SW-1:0] src;
      logic [B-1:0]  data;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        wr_entry;
   entry_t        head;
   logic [W-1:0]  rd_ptr;
   logic [W-1:0]  wr_ptr;
   logic [W:0]    count_nxt;
   logic [CH-1:0] gnt;
   logic          arb_en;
   logic          wr_acc;
   logic          rd_acc;

   // A full queue still takes a write when the head leaves on the same edge.
   assign arb_en = !reset_input_queue && !clr_input_queue
                   && !(full_input_queue && !rd_input_queue);

   rr_arbiter #(.CH(CH)) u_arb (
      .clk               (clk),
      .reset_input_queue (reset_input_queue),
      .clr               (clr_input_queue),
      .req               (wr_input_queue),
      .en                (arb_en),
      .advance           (wr_acc),
      .gnt               (gnt)
   );

   assign wr_ready = gnt;
   assign wr_acc   = |(wr_input_queue & gnt);
   assign rd_acc   = rd_input_queue && !empty_input_queue && !clr_input_queue;

   always_comb begin
      wr_entry = '0;
      for (int i = 0; i < CH; i++) begin
         if (gnt[i]) begin
            wr_entry.src  = SW'(i);
            wr_entry.data = w_data_input_queue[i*B +: B];
         end
      end
   end

   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or posedge reset_input_queue) begin
      if (reset_input_queue) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr_input_queue) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
      end
   end

   // Storage is never cleared; reset and flush only make it unreachable.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_entry;
   end

   assign head               = mem[rd_ptr];
   assign r_data_input_queue = empty_input_queue ? '0 : head.data;
   assign r_src              = empty_input_queue ? '0 : head.src;

   assign empty_input_queue = (count == '0);
   assign full_input_queue  = (count == (W+1)'(DEPTH));
   assign almost_full       = (count >= (W+1)'(DEPTH - AF_MARGIN));

`ifdef SPIKE_QUEUE_STATS_EN
   always_ff @(posedge clk or posedge reset_input_queue) begin
      if (reset_input_queue) begin
         high_water <= '0;
         stall_cnt  <= '0;
      end else if (clr_input_queue) begin
         high_water <= '0;
         stall_cnt  <= '0;
      end else begin
         if (count_nxt > high_water) high_water <= count_nxt;
         if (|wr_input_queue && !wr_acc && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: doc/spike_input_queue_mc.md
Name: spike_input_queue_mc

Overview:
Multi-channel input spike queue for the LIF neuron core.
- Merges up to CH presynaptic spike-index streams into a single FIFO of depth 2^W.
- Arbitration between channels is round-robin.
- The read side is first-word-fall-through (FWFT) and is consumed by the core's spike-processing FSM.
- Generalises the single-port input queue: multiple writers, valid/ready backpressure, occupancy count, almost-full flag, synchronous flush and source tagging.

Parameters:
- B, 8: spike index (data) width.
- W, 4: address width; queue depth is 2^W.
- CH, 2: number of write channels (1..8).
- AF_MARGIN, 2: almost_full asserts when count >= 2^W - AF_MARGIN.

Ports:
- clk  in  1  clock, rising edge.
- reset_input_queue  in  1  asynchronous active-high reset.
- clr_input_queue  in  1  synchronous flush.
- wr_input_queue  in  CH  per-channel write request (valid).
- w_data_input_queue  in  CH*B  per-channel data; channel i occupies bits [i*B +: B].
- wr_ready  out  CH  per-channel accept (grant).
- rd_input_queue  in  1  pop the head entry.
- r_data_input_queue  out  B  head data (FWFT).
- r_src  out  $clog2(CH) (min 1)  channel that wrote the head entry.
- count  out  W+1  current occupancy.
- empty_input_queue  out  1  queue empty.
- full_input_queue  out  1  queue full.
- almost_full  out  1  occupancy threshold flag.

Behaviour:
- Reset (asynchronous): rd_ptr = 0, wr_ptr = 0, count = 0, RR pointer = 0. Outputs: empty = 1, full = 0, almost_full = 0, r_data = 0, r_src = 0, wr_ready = 0.
- Storage: 2^W entries of {src, data}. At most one write accepted per cycle.
- Arbitration (combinational):
  - Requests are scanned starting at the RR pointer; the first requester gets wr_ready.
  - wr_ready is all-zero when (full & !rd_input_queue) or clr_input_queue.
  - A write is accepted when wr_input_queue[i] & wr_ready[i].
  - After an accepted write by channel i, the RR pointer becomes (i+1) mod CH. It is unchanged if nothing is accepted.
- Channel handshake: a requesting channel that is not granted holds its data and request stable. The queue never drops data.
- Read (FWFT):
  - When !empty, r_data and r_src show the head entry combinationally from rd_ptr.
  - When empty, both outputs are 0.
  - rd_input_queue while !empty pops the head on the clock edge.
  - rd_input_queue while empty is ignored; no pointer or count change.
- Simultaneous events:
  - Full with rd and wr: both happen; count stays 2^W and the new entry lands at the tail.
  - Empty with rd and wr: the write is accepted, the read is ignored, and count becomes 1. Written data is visible on r_data the following cycle.
  - Otherwise, rd and wr together leave count unchanged.
- Pointers are W bits and wrap modulo 2^W. count saturates by construction (0..2^W).
- Flags are registered-equivalent functions of count: empty = (count == 0), full = (count == 2^W), almost_full = (count >= 2^W - AF_MARGIN).
- clr_input_queue: on the next edge, pointers, count and RR pointer return to 0. It has priority over any rd or wr in the same cycle; that write is not accepted because wr_ready = 0.
- Reset asserted mid-operation returns immediately to reset values. Contents are not cleared, but they are unreachable.

Optional Feature:
SPIKE_QUEUE_STATS_EN
- Defined: adds outputs high_water (W+1 bits) and stall_cnt (16 bits).
  - high_water = maximum count reached since reset or clr.
  - stall_cnt increments each cycle where |wr_input_queue and no write is accepted. It saturates at 0xFFFF.
  - Both reset to 0 on reset and on clr.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package spike_queue_pkg holds:
  - localparams SPIKE_B = 8 and Q_W = 4;
  - typedef spike_idx_t (logic [SPIKE_B-1:0]);
  - typedef q_entry_t (struct: src, data);
  - function clog2_min1.
- Sub-module rr_arbiter (parameter CH): inputs req[CH], en, advance; output gnt[CH], one-hot. It is combinational grant logic plus the registered RR pointer, reset by reset_input_queue.

Test Plan (B=8, W=4, CH=2, AF_MARGIN=2):
1. Assert reset, then release → empty = 1, full = 0, count = 0, almost_full = 0, r_data = 0, r_src = 0, wr_ready = 00.
2. Channel 0 alone writes 0x00..0x10 → almost_full rises when count reaches 14. full = 1 at count = 16. The 17th request (0x10) sees wr_ready[0] = 0 and is held; after one pop it is accepted.
3. Both channels request continuously, ch0 writing 0xA0.. and ch1 writing 0xB0.. → grants alternate 0,1,0,1. Pops return A0,B0,A1,B1 with r_src = 0,1,0,1.
4. Full queue holding 0x00..0x0F, then rd and wr of 0x55 in the same cycle → count stays 16, r_data becomes 0x01, and 0x55 is popped 16th.
5. Empty queue:
   - rd alone → no change, count = 0.
   - rd and wr of 0x33 together → count = 1, r_data = 0x33 on the next cycle.
6. count = 5, then clr together with a ch1 write of 0x77 → wr_ready = 00, then count = 0 and empty = 1. Next, assert reset mid-burst → outputs return to reset values immediately, asynchronously.
